// File: rtl/matvec_pkg.sv
// Types and defaults shared across the mat-vec multiplier datapath.
// Results are packed into vectors and fed back to the multiplier as the next layer's input.
package matvec_pkg;

  typedef logic signed [15:0] q412_t;

  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int BANDWIDTH_DEFAULT  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LAST    = 2'd2
  } packer_state_e;

endpackage

// File: rtl/result_vector_packer.sv
// Gathers the serial result stream into BANDWIDTH-wide chunks and writes each chunk
// back through the multiplier's vector port, so one layer's output feeds the next layer.
module result_vector_packer
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int BANDWIDTH  = BANDWIDTH_DEFAULT,
  parameter int MAX_LEN    = 64,
  localparam int ADDR_W    = $clog2(MAX_LEN),
  localparam int CNT_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_results,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  result_valid,
  output logic                  vector_write_enable,
  output logic [ADDR_W-1:0]     vector_base_addr,
  output logic [DATA_WIDTH-1:0] vector_out [0:BANDWIDTH-1],
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int LANE_W = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;

  if (MAX_LEN % BANDWIDTH != 0) begin : g_len_check
    $error("result_vector_packer: MAX_LEN must be a multiple of BANDWIDTH");
  end

  packer_state_e state, state_next;

  logic [CNT_W-1:0]      n;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_W-1:0]     base;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] lane_buf [0:BANDWIDTH-1];
  logic [DATA_WIDTH-1:0] merged   [0:BANDWIDTH-1];
  logic [CNT_W-1:0]      n_clamped;

  logic take_start;
  logic accept;
  logic close_chunk;
  logic last_word;

  assign n_clamped = (num_results > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : num_results;

  always_comb begin
    state_next  = state;
    take_start  = 1'b0;
    accept      = 1'b0;
    close_chunk = 1'b0;
    last_word   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          take_start = 1'b1;
          if (n_clamped != '0) state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (result_valid) begin
          accept      = 1'b1;
          last_word   = ((cnt + CNT_W'(1)) == n);
          close_chunk = last_word || (lane == LANE_W'(BANDWIDTH - 1));
          if (last_word) state_next = LAST;
        end
      end
      LAST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Chunk as it would look with the current word dropped into its lane; later lanes read as zero.
  always_comb begin
    for (int j = 0; j < BANDWIDTH; j++) begin
      if (j < int'(lane))       merged[j] = lane_buf[j];
      else if (j == int'(lane)) merged[j] = result_in;
      else                      merged[j] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vector_write_enable <= 1'b0;
      vector_base_addr    <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      overrun             <= 1'b0;
      n                   <= '0;
      cnt                 <= '0;
      base                <= '0;
      lane                <= '0;
      for (int j = 0; j < BANDWIDTH; j++) begin
        lane_buf[j]   <= '0;
        vector_out[j] <= '0;
      end
    end else begin
      vector_write_enable <= 1'b0;
      done                <= 1'b0;

      if (take_start) begin
        overrun <= 1'b0;
        n       <= n_clamped;
        cnt     <= '0;
        base    <= '0;
        lane    <= '0;
        for (int j = 0; j < BANDWIDTH; j++) lane_buf[j] <= '0;
        if (n_clamped == '0) done <= 1'b1;
        else                 busy <= 1'b1;
      end else if (state == IDLE && result_valid) begin
        overrun <= 1'b1;
      end

      if (state == LAST) begin
        busy <= 1'b0;
        if (result_valid) overrun <= 1'b1;
      end

      if (accept) begin
        cnt <= cnt + CNT_W'(1);
        if (close_chunk) begin
          for (int j = 0; j < BANDWIDTH; j++) begin
            vector_out[j] <= merged[j];
            lane_buf[j]   <= '0;
          end
          vector_base_addr    <= base;
          vector_write_enable <= 1'b1;
          base                <= base + ADDR_W'(BANDWIDTH);
          lane                <= '0;
        end else begin
          lane_buf[lane] <= result_in;
          lane           <= lane + LANE_W'(1);
        end
        if (last_word) done <= 1'b1;
      end
    end
  end

endmodule
